serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial N-bit adder controller. It reuses the single one-bit full adder (`structuralFullAdder`) once per clock, one bit per cycle, LSB first. It latches two operands on a start request, sequences WIDTH add steps through a registered carry, and publishes a stable sum, carry-out and signed-overflow flag with a one-cycle done pulse. It is the sequencing layer that turns the one-bit adder cell into a multi-bit arithmetic resource with a start/done handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width in bits, ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request. Sampled only in IDLE.
- `a`  in  WIDTH  operand A. Sampled with `start`.
- `b`  in  WIDTH  operand B. Sampled with `start`.
- `cin`  in  1  carry-in. Sampled with `start`.
- `ready`  out  1  high only in IDLE; a `start` is accepted when `ready && start` at an edge.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle.
- `sum`  out  WIDTH  result, (a+b+cin) mod 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.
- `overflow`  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- State machine, 2-bit encoding:
  - IDLE: transitions to RUN on an accepted start.
  - RUN: lasts exactly WIDTH cycles, then transitions to DONE.
  - DONE: lasts one cycle, then transitions to IDLE.
- On acceptance:
  - `a_sh <= a`, `b_sh <= b`, `carry <= cin`, `acc <= 0`, `cnt <= 0`.
- Each RUN cycle:
  - Full adder inputs are `a_sh[0]`, `b_sh[0]`, `carry`.
  - At the edge: `a_sh` and `b_sh` shift right by 1, `acc <= {fa_sum, acc[WIDTH-1:1]}`, `carry <= fa_cout`, `cnt <= cnt+1`.
  - On the step where `cnt == WIDTH-1`: `msb_cin <= carry` (the carry into the MSB), and state moves to DONE.
- Entry to DONE (the same edge as the last step):
  - `sum <= final acc`, `cout <= fa_cout`, `overflow <= msb_cin XOR fa_cout`.
  - `done` is high for exactly that DONE cycle.
- `sum`, `cout` and `overflow` are result registers, never the shift register. They hold their value until the next DONE entry, so partial results are never visible.
- `start` is ignored in RUN and DONE. No queuing: a request held high is re-sampled in the next IDLE cycle.
- Operand inputs may change freely after acceptance.
- Reset (`rst_n` low at an edge), from any state including mid-RUN:
  - State goes to IDLE.
  - `sum`=0, `cout`=0, `overflow`=0, `done`=0, `busy`=0.
  - `ready`=1 after the edge.
  - Internal registers are cleared. No done pulse is produced for an aborted operation.
- WIDTH=1: RUN lasts one cycle. Overflow equals cin XOR cout.

## Timing
- Start accepted at edge E0.
- `busy` is high from E0 to E0+WIDTH.
- `done` is high from E0+WIDTH to E0+WIDTH+1.
- Start-to-done latency is WIDTH cycles. IDLE is re-entered at E0+WIDTH+1.
- Maximum throughput is one operation per WIDTH+2 cycles. With `start` held continuously high, accepts occur at E0, E0+WIDTH+2, and so on.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- `ready`, `busy` and `done` are decoded directly from state flops.
- Critical path: one full-adder stage plus flop setup.

## Structure
- Shared include `serial_adder_defs.vh` holds:
  - state encodings `S_IDLE`=0, `S_RUN`=1, `S_DONE`=2;
  - the counter width macro, ceil(log2(WIDTH)), minimum 1.
- Sub-module: one instance of `structuralFullAdder` in port order (sum, carryout, a, b, carryin) is the only arithmetic.
- No other adders are permitted in the block; the counter increment is exempt.
- Counter, shift registers, carry flop and result registers stay in this module.

## Test plan (WIDTH=8 unless noted)
- 0x0F + 0x01, cin=0, start at E0 → `done` at E0+8; `sum`=0x10, `cout`=0, `overflow`=0; `busy` high for 8 cycles, `ready` low 9 cycles.
- 0xFF + 0x01, cin=0 → `sum`=0x00, `cout`=1, `overflow`=0. Then 0x7F + 0x01 → `sum`=0x80, `cout`=0, `overflow`=1. Then 0x80 + 0x80, cin=1 → `sum`=0x01, `cout`=1, `overflow`=1.
- `start` held high with operands changing every cycle → accepts exactly every 10 cycles. Each result matches the operands sampled at its accept edge; starts during RUN/DONE are ignored. Previous `sum` is stable throughout RUN.
- `rst_n` low for one edge at the 4th RUN cycle → next cycle in IDLE, `ready`=1, all outputs 0, no `done` pulse. A new start then completes normally.
- WIDTH=4: exhaustive a, b, cin (512 cases) → `{cout,sum}` == a+b+cin; `overflow` matches the signed-sum check.
- WIDTH=1: 1+1, cin=1 → `done` one cycle after accept; `sum`=1, `cout`=1, `overflow`=0.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    // Controller states; encodings are fixed so they can be observed on a probe.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bits needed to count WIDTH steps (0 .. WIDTH-1), never less than one.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/structuralFullAdder.sv
// One-bit full adder built from gates; the only arithmetic cell in the controller.
module structuralFullAdder (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);

    logic axb;

    assign axb      = a ^ b;
    assign sum      = axb ^ carryin;
    assign carryout = (a & b) | (axb & carryin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first, with a
// start/ready handshake and a one-cycle done pulse. Results live in dedicated
// registers so partial sums never reach the outputs.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, b_sh_q, acc_q, acc_next;
    logic              carry_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q, overflow_q;
    logic              fa_sum, fa_cout;
    logic              last_step;

    structuralFullAdder u_fa (
        .sum      (fa_sum),
        .carryout (fa_cout),
        .a        (a_sh_q[0]),
        .b        (b_sh_q[0]),
        .carryin  (carry_q)
    );

    assign last_step = (cnt_q == CntW'(WIDTH - 1));
    // New bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
    assign acc_next  = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_step) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand latch, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (state_q == StIdle) begin
            if (start) begin
                a_sh_q  <= a;
                b_sh_q  <= b;
                carry_q <= cin;
                acc_q   <= '0;
                cnt_q   <= '0;
            end
        end else if (state_q == StRun) begin
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            acc_q   <= acc_next;
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CntW'(1);
            if (last_step) begin
                // carry_q here is the carry into the MSB.
                sum_q      <= acc_next;
                cout_q     <= fa_cout;
                overflow_q <= carry_q ^ fa_cout;
            end
        end
    end

    assign ready    = (state_q == StIdle);
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH 8, 4 and 1 against an arithmetic model.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, start4, start1;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       a1, b1;
    logic       cin8, cin4, cin1;
    logic       ready8, busy8, done8, cout8, ovf8;
    logic       ready4, busy4, done4, cout4, ovf4;
    logic       ready1, busy1, done1, cout1, ovf1;
    logic [7:0] sum8;
    logic [3:0] sum4;
    logic       sum1;

    int ncmp = 0;
    int nfail = 0;

    // Last published result per width, as the model sees it.
    logic [7:0] held_sum [3];
    logic       held_cout [3];
    logic       held_ovf [3];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );
    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input int w);
        return (w == 8) ? 0 : (w == 4) ? 1 : 2;
    endfunction

    // Status vector {ready,busy,done,cout,ovf} of the chosen instance.
    function automatic logic [4:0] status(input int w);
        case (w)
            8:       return {ready8, busy8, done8, cout8, ovf8};
            4:       return {ready4, busy4, done4, cout4, ovf4};
            default: return {ready1, busy1, done1, cout1, ovf1};
        endcase
    endfunction

    function automatic logic [7:0] get_sum(input int w);
        case (w)
            8:       return sum8;
            4:       return {4'd0, sum4};
            default: return {7'd0, sum1};
        endcase
    endfunction

    task automatic drive(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv);
        case (w)
            8:       begin start8 = s; a8 = av;      b8 = bv;      cin8 = cv; end
            4:       begin start4 = s; a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv; end
            default: begin start1 = s; a1 = av[0];   b1 = bv[0];   cin1 = cv; end
        endcase
    endtask

    // Reference: plain integer addition and the signed-operand overflow rule.
    task automatic model(input int w, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         output logic [7:0] es, output logic ec, output logic eo);
        int unsigned mask, ua, ub, total;
        logic sa, sb, ss;
        mask  = (32'd1 << w) - 1;
        ua    = av & mask;
        ub    = bv & mask;
        total = ua + ub + cv;
        es    = 8'(total & mask);
        ec    = total[w];
        sa    = ua[w-1];
        sb    = ub[w-1];
        ss    = es[w-1];
        eo    = (sa == sb) && (ss != sa);
    endtask

    // One complete operation with handshake, latency and stability checks.
    task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [7:0] es;
        logic ec, eo;
        logic [4:0] st;
        int lat;
        int k;
        k = idx(w);
        model(w, av, bv, cv, es, ec, eo);
        check($sformatf("w%0d ready_pre", w), 32'(status(w) >> 4), 1);
        drive(w, 1'b1, av, bv, cv);
        @(negedge clk);
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        lat = 0;
        while (status(w)[2] !== 1'b1 && lat < 40) begin
            st = status(w);
            check($sformatf("w%0d run_rdy_busy", w), 32'(st[4:3]), 32'b01);
            check($sformatf("w%0d sum_stable", w), 32'(get_sum(w)), 32'(held_sum[k]));
            @(negedge clk);
            drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            lat++;
        end
        check($sformatf("w%0d latency", w), lat, w);
        st = status(w);
        check($sformatf("w%0d done_flags", w), 32'(st[4:2]), 32'b001);
        check($sformatf("w%0d sum %0h+%0h+%0h", w, av, bv, cv), 32'(get_sum(w)), 32'(es));
        check($sformatf("w%0d cout", w), 32'(st[1]), 32'(ec));
        check($sformatf("w%0d ovf", w), 32'(st[0]), 32'(eo));
        held_sum[k]  = es;
        held_cout[k] = ec;
        held_ovf[k]  = eo;
        @(negedge clk);
        st = status(w);
        check($sformatf("w%0d back_idle", w), 32'(st[4:2]), 32'b100);
        check($sformatf("w%0d sum_hold", w), 32'(get_sum(w)), 32'(es));
    endtask

    initial begin
        logic [7:0] qa [$];
        logic [7:0] qb [$];
        logic       qc [$];
        logic [7:0] es, ra, rb;
        logic ec, eo, rc;

        rst_n = 1'b0;
        drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            held_sum[i] = '0; held_cout[i] = 1'b0; held_ovf[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset status8", 32'(status(8)), 32'b10000);
        check("reset sum8", 32'(sum8), 0);
        check("reset status4", 32'(status(4)), 32'b10000);
        check("reset status1", 32'(status(1)), 32'b10000);
        @(negedge clk);

        // Directed cases.
        op(8, 8'h0F, 8'h01, 1'b0);
        op(8, 8'hFF, 8'h01, 1'b0);
        op(8, 8'h7F, 8'h01, 1'b0);
        op(8, 8'h80, 8'h80, 1'b1);
        op(8, 8'h00, 8'h00, 1'b0);
        op(8, 8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 20; i++) op(8, 8'($urandom), 8'($urandom), 1'($urandom));

        // Start held high with operands changing every cycle.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            drive(8, 1'b1, ra, rb, rc);
            check("held ready", 32'(ready8), 32'(i % 10 == 0));
            if (i % 10 == 0) begin
                qa.push_back(ra); qb.push_back(rb); qc.push_back(rc);
            end
            check("held done", 32'(done8), 32'(i % 10 == 9));
            if (i % 10 == 9) begin
                model(8, qa.pop_front(), qb.pop_front(), qc.pop_front(), es, ec, eo);
                check("held sum", 32'(sum8), 32'(es));
                check("held cout", 32'(cout8), 32'(ec));
                check("held ovf", 32'(ovf8), 32'(eo));
                held_sum[0] = es; held_cout[0] = ec; held_ovf[0] = eo;
            end else begin
                check("held sum_stable", 32'(sum8), 32'(held_sum[0]));
            end
            @(negedge clk);
        end
        drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);

        // Reset in the 4th RUN cycle aborts the operation silently.
        drive(8, 1'b1, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("abort busy_before", 32'(busy8), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort status8", 32'(status(8)), 32'b10000);
        check("abort sum8", 32'(sum8), 0);
        for (int i = 0; i < 3; i++) begin
            held_sum[i] = '0; held_cout[i] = 1'b0; held_ovf[i] = 1'b0;
        end
        for (int i = 0; i < 12; i++) begin
            check("abort no_done", 32'(done8), 0);
            @(negedge clk);
        end
        op(8, 8'h55, 8'hAA, 1'b1);

        // WIDTH=4 exhaustive.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    op(4, 8'(x), 8'(y), 1'(c));

        // WIDTH=1.
        op(1, 8'd1, 8'd1, 1'b1);
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                for (int c = 0; c < 2; c++)
                    op(1, 8'(x), 8'(y), 1'(c));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
